vadd_issue_ctrl: RTL and testbench

VADD_ISSUE_CTRL -- requirements
Module: vadd_issue_ctrl

---
 rtl/vadd_issue_ctrl_if.sv | 55 +++++
 rtl/vadd_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vadd_issue_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_issue_ctrl_if.sv
// rtl/vadd_issue_ctrl_if.sv - command, operand, ALU-issue and status bundle for vadd_issue_ctrl
interface vadd_issue_ctrl_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int VL_WIDTH    = 16,
   parameter int OPSEL_WIDTH = 9
);
   localparam int BE_W = DATA_WIDTH / 8;

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [VL_WIDTH-1:0]    cmd_vl;
   logic [1:0]             cmd_sew;
   logic [OPSEL_WIDTH-1:0] cmd_opsel;
   logic                   cmd_avg;
   logic [ADDR_WIDTH-1:0]  cmd_addr;

   logic                   op_valid;
   logic                   op_ready;
   logic [DATA_WIDTH-1:0]  op_vec0;
   logic [DATA_WIDTH-1:0]  op_vec1;

   logic                   alu_valid;
   logic [DATA_WIDTH-1:0]  alu_vec0;
   logic [DATA_WIDTH-1:0]  alu_vec1;
   logic [1:0]             alu_sew;
   logic [OPSEL_WIDTH-1:0] alu_opsel;
   logic [ADDR_WIDTH-1:0]  alu_addr;
   logic [2:0]             alu_start_idx;
   logic                   alu_req_start;
   logic                   alu_req_end;
   logic [BE_W-1:0]        alu_be;
   logic                   alu_avg;

   logic                   busy;
   logic                   done;

   modport master (
      output cmd_valid, cmd_vl, cmd_sew, cmd_opsel, cmd_avg, cmd_addr,
      output op_valid, op_vec0, op_vec1,
      input  cmd_ready, op_ready,
      input  alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_addr,
      input  alu_start_idx, alu_req_start, alu_req_end, alu_be, alu_avg,
      input  busy, done
   );

   modport slave (
      input  cmd_valid, cmd_vl, cmd_sew, cmd_opsel, cmd_avg, cmd_addr,
      input  op_valid, op_vec0, op_vec1,
      output cmd_ready, op_ready,
      output alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opsel, alu_addr,
      output alu_start_idx, alu_req_start, alu_req_end, alu_be, alu_avg,
      output busy, done
   );
endinterface

// File: rtl/vadd_issue_ctrl.sv
// rtl/vadd_issue_ctrl.sv - splits a vector-add command into per-beat ALU issues
// and pulses done once the last beat has left the fixed-latency ALU pipeline.
module vadd_issue_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int VL_WIDTH    = 16,
   parameter int OPSEL_WIDTH = 9,
   parameter int ALU_LATENCY = 7
) (
   input logic              clk,
   input logic              rst,
   vadd_issue_ctrl_if.slave bus
);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(ALU_LATENCY + 1);
   localparam int VLR_W = VL_WIDTH + 1;
   localparam int BIT_W = VL_WIDTH + 3;
   localparam logic [BE_W-1:0] BE_ONE = BE_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [1:0]             sew_q;
   logic [OPSEL_WIDTH-1:0] opsel_q;
   logic                   avg_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [VL_WIDTH-1:0]    nbeats_q;
   logic [VL_WIDTH-1:0]    beat_idx;
   logic [2:0]             rem_q;
   logic [CNT_W-1:0]       drain_cnt;
   logic                   done_q;

   logic                   alu_valid_q;
   logic [DATA_WIDTH-1:0]  alu_vec0_q;
   logic [DATA_WIDTH-1:0]  alu_vec1_q;
   logic [1:0]             alu_sew_q;
   logic [OPSEL_WIDTH-1:0] alu_opsel_q;
   logic [ADDR_WIDTH-1:0]  alu_addr_q;
   logic [2:0]             alu_start_q;
   logic                   alu_req_start_q;
   logic                   alu_req_end_q;
   logic [BE_W-1:0]        alu_be_q;
   logic                   alu_avg_q;

   logic                   cmd_ready_w;
   logic                   op_ready_w;
   logic                   accept;
   logic                   issue;
   logic                   last_beat;
   logic                   is_mask;
   logic [VLR_W-1:0]       vl_round;
   logic [VL_WIDTH-1:0]    nbeats_w;
   logic [2:0]             rem_w;
   logic [BIT_W-1:0]       mask_bits;
   logic [BE_W-1:0]        be_tail;
   logic [ADDR_WIDTH-1:0]  beat_addr;
   logic [2:0]             beat_start;
   logic [BE_W-1:0]        beat_be;

   assign cmd_ready_w = (state == S_IDLE) && !rst;
   assign op_ready_w  = (state == S_ISSUE) && !rst;
   assign accept      = bus.cmd_valid && cmd_ready_w;
   assign issue       = bus.op_valid && op_ready_w;

   // Beat count rounds vl up to whole beats; the tail byte count comes from vl's low bits only.
   always_comb begin
      vl_round = {1'b0, bus.cmd_vl} + VLR_W'((4'd8 >> bus.cmd_sew) - 4'd1);
      nbeats_w = VL_WIDTH'(vl_round >> (2'd3 - bus.cmd_sew));
      rem_w    = bus.cmd_vl[2:0] << bus.cmd_sew;
   end

   assign is_mask   = opsel_q[8];
   assign last_beat = (beat_idx == nbeats_q - VL_WIDTH'(1));
   assign mask_bits = {beat_idx, 3'b000} >> sew_q;
   assign be_tail   = (rem_q == 3'd0) ? '1 : (BE_ONE << rem_q) - BE_ONE;

   // Mask results pack one bit per element, so a beat only moves the address every 64 bits.
   always_comb begin
      beat_addr  = addr_q + ADDR_WIDTH'(beat_idx);
      beat_start = 3'd0;
      beat_be    = last_beat ? be_tail : '1;
      if (is_mask) begin
         beat_addr  = addr_q + ADDR_WIDTH'(mask_bits >> 6);
         beat_start = mask_bits[2:0];
         beat_be    = BE_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = (bus.cmd_vl != '0) ? S_ISSUE : S_DRAIN;
         end
         S_ISSUE: begin
            if (issue && last_beat) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt == '0) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sew_q     <= '0;
         opsel_q   <= '0;
         avg_q     <= 1'b0;
         addr_q    <= '0;
         nbeats_q  <= '0;
         beat_idx  <= '0;
         rem_q     <= '0;
         drain_cnt <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            sew_q     <= bus.cmd_sew;
            opsel_q   <= bus.cmd_opsel;
            avg_q     <= bus.cmd_avg;
            addr_q    <= bus.cmd_addr;
            nbeats_q  <= nbeats_w;
            rem_q     <= rem_w;
            beat_idx  <= '0;
            drain_cnt <= '0;
         end
         if (issue) begin
            beat_idx <= beat_idx + VL_WIDTH'(1);
            if (last_beat) drain_cnt <= CNT_W'(ALU_LATENCY - 1);
         end
         if (state == S_DRAIN) begin
            if (drain_cnt == '0) done_q <= 1'b1;
            else                 drain_cnt <= drain_cnt - CNT_W'(1);
         end
      end
   end

   // Issue registers read as zero whenever no beat is presented.
   always_ff @(posedge clk) begin
      if (rst || !issue) begin
         alu_valid_q     <= 1'b0;
         alu_vec0_q      <= '0;
         alu_vec1_q      <= '0;
         alu_sew_q       <= '0;
         alu_opsel_q     <= '0;
         alu_addr_q      <= '0;
         alu_start_q     <= '0;
         alu_req_start_q <= 1'b0;
         alu_req_end_q   <= 1'b0;
         alu_be_q        <= '0;
         alu_avg_q       <= 1'b0;
      end else begin
         alu_valid_q     <= 1'b1;
         alu_vec0_q      <= bus.op_vec0;
         alu_vec1_q      <= bus.op_vec1;
         alu_sew_q       <= sew_q;
         alu_opsel_q     <= opsel_q;
         alu_addr_q      <= beat_addr;
         alu_start_q     <= beat_start;
         alu_req_start_q <= (beat_idx == '0);
         alu_req_end_q   <= last_beat;
         alu_be_q        <= beat_be;
         alu_avg_q       <= avg_q;
      end
   end

   assign bus.cmd_ready     = cmd_ready_w;
   assign bus.op_ready      = op_ready_w;
   assign bus.busy          = (state != S_IDLE) && !rst;
   assign bus.done          = done_q;
   assign bus.alu_valid     = alu_valid_q;
   assign bus.alu_vec0      = alu_vec0_q;
   assign bus.alu_vec1      = alu_vec1_q;
   assign bus.alu_sew       = alu_sew_q;
   assign bus.alu_opsel     = alu_opsel_q;
   assign bus.alu_addr      = alu_addr_q;
   assign bus.alu_start_idx = alu_start_q;
   assign bus.alu_req_start = alu_req_start_q;
   assign bus.alu_req_end   = alu_req_end_q;
   assign bus.alu_be        = alu_be_q;
   assign bus.alu_avg       = alu_avg_q;
endmodule

// File: tb/tb_vadd_issue_ctrl.sv
// tb/tb_vadd_issue_ctrl.sv - randomized bench for vadd_issue_ctrl against a
// per-command beat model that predicts every output each cycle.
module tb_vadd_issue_ctrl;
   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int VW  = 16;
   localparam int OW  = 9;
   localparam int LAT = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vadd_issue_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VW), .OPSEL_WIDTH(OW)) bus ();

   vadd_issue_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VW), .OPSEL_WIDTH(OW), .ALU_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: command in flight, beats issued so far, and cycles left until done.
   bit          m_idle = 1'b1;
   bit          m_issuing = 1'b0;
   int          m_wait = 0;
   int          m_k = 0;
   int          m_nb = 0;
   int unsigned m_vl = 0;
   int          m_sew = 0;
   logic [8:0]  m_opsel = '0;
   bit          m_avg = 1'b0;
   logic [31:0] m_addr = '0;

   bit          e_valid, e_done, e_rs, e_re, e_avg;
   logic [63:0] e_v0, e_v1;
   logic [31:0] e_addr;
   logic [2:0]  e_start;
   logic [7:0]  e_be;
   logic [1:0]  e_sew;
   logic [8:0]  e_opsel;

   function automatic int beats_of(input int unsigned vl, input int sew);
      int epb;
      epb = 8 >> sew;
      return int'((vl + epb - 1) / epb);
   endfunction

   task automatic model_edge();
      int epb, bits, rem;
      e_valid = 0; e_done = 0; e_rs = 0; e_re = 0; e_avg = 0;
      e_v0 = '0; e_v1 = '0; e_addr = '0; e_start = '0; e_be = '0; e_sew = '0; e_opsel = '0;
      if (rst) begin
         m_idle = 1; m_issuing = 0; m_wait = 0;
      end else if (m_idle) begin
         if (bus.cmd_valid) begin
            m_vl = bus.cmd_vl; m_sew = bus.cmd_sew; m_opsel = bus.cmd_opsel;
            m_avg = bus.cmd_avg; m_addr = bus.cmd_addr;
            m_k = 0; m_nb = beats_of(m_vl, m_sew); m_idle = 0;
            if (m_nb == 0) m_wait = 1;
            else           m_issuing = 1;
         end
      end else if (m_issuing) begin
         if (bus.op_valid) begin
            epb  = 8 >> m_sew;
            bits = m_k * epb;
            e_valid = 1; e_v0 = bus.op_vec0; e_v1 = bus.op_vec1;
            e_sew = 2'(m_sew); e_opsel = m_opsel; e_avg = m_avg;
            e_rs = (m_k == 0); e_re = (m_k == m_nb - 1);
            if (m_opsel[8]) begin
               e_addr  = m_addr + 32'(bits / 64);
               e_start = 3'(bits % 8);
               e_be    = 8'h01;
            end else begin
               rem     = int'((m_vl * (1 << m_sew)) % 8);
               e_addr  = m_addr + 32'(m_k);
               e_start = 3'd0;
               e_be    = (e_re && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            end
            m_k++;
            if (m_k == m_nb) begin
               m_issuing = 0;
               m_wait = LAT;
            end
         end
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            e_done = 1;
            m_idle = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      chk("cmd_ready", bus.cmd_ready, m_idle && !rst);
      chk("op_ready", bus.op_ready, m_issuing && !rst);
      chk("busy", bus.busy, !m_idle && !rst);
      chk("done", bus.done, e_done);
      chk("alu_valid", bus.alu_valid, e_valid);
      chk("alu_vec0", bus.alu_vec0, e_v0);
      chk("alu_vec1", bus.alu_vec1, e_v1);
      chk("alu_sew", bus.alu_sew, e_sew);
      chk("alu_opsel", bus.alu_opsel, e_opsel);
      chk("alu_avg", bus.alu_avg, e_avg);
      chk("alu_addr", bus.alu_addr, e_addr);
      chk("alu_start_idx", bus.alu_start_idx, e_start);
      chk("alu_req_start", bus.alu_req_start, e_rs);
      chk("alu_req_end", bus.alu_req_end, e_re);
      chk("alu_be", bus.alu_be, e_be);
   endtask

   // mode 0: op_valid held high; 1: random stalls; 2: four idle cycles after beat 0
   task automatic run_cmd(input int unsigned vl, input int sew, input logic [8:0] opsel,
                          input bit avg, input logic [31:0] addr, input int mode);
      int cyc, gap;
      bus.cmd_valid = 1'b1;
      bus.cmd_vl    = 16'(vl);
      bus.cmd_sew   = 2'(sew);
      bus.cmd_opsel = opsel;
      bus.cmd_avg   = avg;
      bus.cmd_addr  = addr;
      bus.op_valid  = 1'b0;
      tick();
      cyc = 0;
      gap = 0;
      while (!m_idle && cyc < 2000) begin
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd_vl    = 16'($urandom);
         bus.cmd_sew   = 2'($urandom_range(0, 3));
         bus.cmd_opsel = 9'($urandom);
         bus.cmd_addr  = $urandom;
         if (m_issuing) begin
            if (mode == 2 && m_k == 1 && gap < 4) begin
               bus.op_valid = 1'b0;
               gap++;
            end else if (mode == 1) begin
               bus.op_valid = ($urandom_range(0, 3) != 0);
            end else begin
               bus.op_valid = 1'b1;
            end
         end else begin
            bus.op_valid = 1'($urandom_range(0, 1));
         end
         bus.op_vec0 = {$urandom, $urandom};
         bus.op_vec1 = {$urandom, $urandom};
         tick();
         cyc++;
      end
      chk("cmd_budget", 64'(m_idle), 64'd1);
      bus.cmd_valid = 1'b0;
      bus.op_valid  = 1'b0;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.op_valid = 1'($urandom_range(0, 1));
         bus.op_vec0  = {$urandom, $urandom};
         tick();
      end
      bus.op_valid = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      bus.cmd_valid = 1'b0; bus.cmd_vl = '0; bus.cmd_sew = '0; bus.cmd_opsel = '0;
      bus.cmd_avg = 1'b0; bus.cmd_addr = '0; bus.op_valid = 1'b0;
      bus.op_vec0 = '0; bus.op_vec1 = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      run_cmd(20, 0, 9'h000, 1'b0, 32'h100, 0);
      run_cmd(10, 2, 9'h100, 1'b0, 32'h40, 0);
      run_cmd(3, 3, 9'h0A5, 1'b1, 32'h80, 2);
      run_cmd(0, 1, 9'h003, 1'b0, 32'h10, 0);
      idle_ticks(2);
      run_cmd(64, 1, 9'h1C2, 1'b0, 32'h300, 0);
      run_cmd(40, 0, 9'h011, 1'b1, 32'hFFFF_FFFE, 1);
      run_cmd(200, 0, 9'h100, 1'b0, 32'hFFFF_FFFF, 1);

      // Reset during the second of three beats abandons the command.
      bus.cmd_valid = 1'b1; bus.cmd_vl = 16'd3; bus.cmd_sew = 2'd3;
      bus.cmd_opsel = 9'h000; bus.cmd_addr = 32'h200;
      tick();
      bus.cmd_valid = 1'b0;
      bus.op_valid = 1'b1; bus.op_vec0 = {$urandom, $urandom};
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_ticks(12);

      for (int i = 0; i < 30; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         run_cmd(($urandom_range(0, 7) == 0) ? $urandom_range(0, 600) : $urandom_range(0, 24),
                 $urandom_range(0, 3), 9'($urandom), 1'($urandom_range(0, 1)), a,
                 $urandom_range(0, 2));
         idle_ticks($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
